// File: rtl/add_share_ctrl_pkg.sv
// Shared state codes and requester IDs for the two-client serial adder.
package add_share_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/gate_lib.sv
// Gate-library cells, each expressed in NOR form to mirror the silicon library.
module my_xor (
    output logic y,
    input  logic a,
    input  logic b
);
    logic n_ab;
    assign n_ab = ~(a | b);
    assign y    = ~(n_ab | ~(~a | ~b));
endmodule

module my_and (
    output logic y,
    input  logic a,
    input  logic b
);
    assign y = ~(~a | ~b);
endmodule

module my_or (
    output logic y,
    input  logic a,
    input  logic b
);
    assign y = ~(~(a | b));
endmodule

// File: rtl/serial_fa_cell.sv
// 1-bit full adder built only from gate-library cells; purely combinational.
module serial_fa_cell (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);
    logic p;
    logic g;
    logic t;

    my_xor u_x0 (.y(p),  .a(a), .b(b));
    my_xor u_x1 (.y(s),  .a(p), .b(ci));
    my_and u_a0 (.y(g),  .a(a), .b(b));
    my_and u_a1 (.y(t),  .a(p), .b(ci));
    my_or  u_o0 (.y(co), .a(g), .b(t));
endmodule

// File: rtl/add_share_ctrl.sv
// Round-robin shares one serial full-adder cell between two requesters,
// adding WIDTH-bit operands LSB first and returning a tagged completion pulse.
module add_share_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    import add_share_ctrl_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    count;
    logic             last_grant;
    logic             grant_reg;
    logic             grant_vld;
    logic             grant_id;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    serial_fa_cell u_fa (
        .s  (fa_s),
        .co (fa_co),
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry)
    );

    assign last_bit = (count == CW'(WIDTH - 1));

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant_vld = (state == ST_IDLE) && (req0 || req1);
        grant_id  = ID_REQ0;
        if (req0 && req1)
            grant_id = ~last_grant;
        else if (req1)
            grant_id = ID_REQ1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant_vld) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_bit)  state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_SHIFT) || (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            sum_sr     <= '0;
            carry      <= 1'b0;
            count      <= '0;
            last_grant <= 1'b1;
            grant_reg  <= ID_REQ0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            sum        <= '0;
            cout       <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        a_sr       <= (grant_id == ID_REQ1) ? a1 : a0;
                        b_sr       <= (grant_id == ID_REQ1) ? b1 : b0;
                        carry      <= (grant_id == ID_REQ1) ? cin1 : cin0;
                        count      <= '0;
                        grant_reg  <= grant_id;
                        last_grant <= grant_id;
                        ack0       <= (grant_id == ID_REQ0);
                        ack1       <= (grant_id == ID_REQ1);
                    end
                end
                ST_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
                    carry  <= fa_co;
                    count  <= count + CW'(1);
                    // The final bit is folded in directly so sum is complete on this edge.
                    if (last_bit) begin
                        sum     <= {fa_s, sum_sr[WIDTH-1:1]};
                        cout    <= fa_co;
                        done    <= 1'b1;
                        done_id <= grant_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_share_ctrl.sv
// Bench for add_share_ctrl: vector table, random ops against an arithmetic
// model, and hand-written arbitration/reset/withdrawal sequences.
`timescale 1ns/10ps
module tb_add_share_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             cin0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             cin1;
    logic             ack0;
    logic             ack1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    add_share_ctrl #(.WIDTH(WIDTH), .CW(5)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
        .ack0(ack0), .ack1(ack1), .busy(busy), .done(done),
        .done_id(done_id), .sum(sum), .cout(cout)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
    } vec_t;

    typedef struct {
        logic             id;
        logic [WIDTH:0]   res;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic c);
        longint x;
        x = longint'(a) + longint'(b) + longint'(c);
        return x[WIDTH:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic [WIDTH-1:0] es, input logic ec);
        int   n;
        logic got;
        logic other;
        logic busy_ok;
        @(negedge clk);
        if (id == 1'b0) begin req0 = 1'b1; a0 = a; b0 = b; cin0 = c; end
        else            begin req1 = 1'b1; a1 = a; b1 = b; cin1 = c; end
        n = 0; got = 1'b0; other = 1'b0;
        while (n < 50 && !got) begin
            @(negedge clk);
            n++;
            if ((id ? ack1 : ack0) === 1'b1) got = 1'b1;
            if ((id ? ack0 : ack1) === 1'b1) other = 1'b1;
        end
        chk("ack_latency", n, 1);
        req0 = 1'b0;
        req1 = 1'b0;
        if (!got) return;
        n = 0; got = 1'b0; busy_ok = 1'b1;
        while (n < 50 && !got) begin
            @(negedge clk);
            n++;
            if (ack0 || ack1) other = 1'b1;
            if (done === 1'b1) got = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        chk("done_latency", n, WIDTH);
        chk("sum", sum, es);
        chk("cout", cout, ec);
        chk("done_id", done_id, id);
        chk("other_ack", other, 0);
        chk("busy_during_op", busy_ok, 1);
        @(negedge clk);
        chk("done_pulse_width", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        int               t_ack0;
        int               t_ack1;
        int               n_done;
        int               n_ack;
        int               n_ack0;
        int               ack_busy_err;
        logic             prev_busy;
        logic             ids[$];
        logic [WIDTH:0]   r;
        exp_t             e;
        logic             seen_done;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; cin0 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

        vecs[0] = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        for (int i = 4; i < 16; i++) begin
            vecs[i].id  = 1'($urandom_range(0, 1));
            vecs[i].a   = WIDTH'($urandom);
            vecs[i].b   = WIDTH'($urandom);
            vecs[i].cin = 1'($urandom_range(0, 1));
            r = ref_add(vecs[i].a, vecs[i].b, vecs[i].cin);
            vecs[i].exp_sum  = r[WIDTH-1:0];
            vecs[i].exp_cout = r[WIDTH];
        end

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ack0", ack0, 0);
        chk("reset_ack1", ack1, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_done_id", done_id, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout", cout, 0);

        for (int i = 0; i < 16; i++)
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout);

        // Simultaneous requests straight after reset: requester 0 first.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        a0 = 8'h12; b0 = 8'h34; cin0 = 1'b1;
        a1 = 8'hC0; b1 = 8'h55; cin1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        t_ack0 = -1; t_ack1 = -1; n_done = 0; ids.delete();
        for (int k = 0; k < 60 && n_done < 2; k++) begin
            @(negedge clk);
            if (ack0) begin t_ack0 = cyc; req0 = 1'b0; end
            if (ack1) begin t_ack1 = cyc; req1 = 1'b0; end
            if (done) begin
                ids.push_back(done_id);
                r = done_id ? ref_add(8'hC0, 8'h55, 1'b0) : ref_add(8'h12, 8'h34, 1'b1);
                chk("tie_result", {cout, sum}, r);
                n_done++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("tie_done_count", n_done, 2);
        if (n_done == 2) begin
            chk("tie_first_id", ids[0], 0);
            chk("tie_second_id", ids[1], 1);
        end
        chk("tie_grant_spacing", t_ack1 - t_ack0, WIDTH + 2);

        // Continuous re-requests must alternate and never ack mid-operation.
        @(negedge clk);
        a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); cin0 = 1'($urandom_range(0, 1));
        a1 = WIDTH'($urandom); b1 = WIDTH'($urandom); cin1 = 1'($urandom_range(0, 1));
        req0 = 1'b1; req1 = 1'b1;
        n_done = 0; n_ack = 0; ack_busy_err = 0; prev_busy = busy; ids.delete(); sb.delete();
        for (int k = 0; k < 400 && n_done < 4; k++) begin
            @(negedge clk);
            if ((ack0 || ack1) && prev_busy) ack_busy_err++;
            if (done) begin
                if (sb.size() == 0) chk("rr_unexpected_done", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("rr_done_id", done_id, e.id);
                    chk("rr_result", {cout, sum}, e.res);
                end
                n_done++;
            end
            if (ack0) begin
                sb.push_back('{1'b0, ref_add(a0, b0, cin0)});
                ids.push_back(1'b0); n_ack++; req0 = 1'b0;
                a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); cin0 = 1'($urandom_range(0, 1));
            end else if (n_ack < 4) req0 = 1'b1;
            if (ack1) begin
                sb.push_back('{1'b1, ref_add(a1, b1, cin1)});
                ids.push_back(1'b1); n_ack++; req1 = 1'b0;
                a1 = WIDTH'($urandom); b1 = WIDTH'($urandom); cin1 = 1'($urandom_range(0, 1));
            end else if (n_ack < 4) req1 = 1'b1;
            if (n_ack >= 4) begin req0 = 1'b0; req1 = 1'b0; end
            prev_busy = busy;
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_done_count", n_done, 4);
        chk("rr_ack_while_busy", ack_busy_err, 0);
        if (ids.size() == 4) begin
            chk("rr_first_id", ids[0], 0);
            for (int i = 1; i < 4; i++) chk("rr_alternate", ids[i] != ids[i-1], 1);
        end else chk("rr_ack_count", ids.size(), 4);
        @(negedge clk);

        // Asynchronous reset mid-operation with a nonzero result held.
        run_op(1'b1, 8'h40, 8'h02, 1'b0, 8'h42, 1'b0);
        @(negedge clk);
        req0 = 1'b1; a0 = 8'h77; b0 = 8'h11; cin0 = 1'b0;
        n_ack0 = 0;
        for (int k = 0; k < 10 && n_ack0 == 0; k++) begin
            @(negedge clk);
            if (ack0) n_ack0 = 1;
        end
        req0 = 1'b0;
        chk("rst_op_acked", n_ack0, 1);
        repeat (4) @(posedge clk);
        #5 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done_id", done_id, 0);
        chk("async_rst_sum", sum, 0);
        chk("async_rst_flags", {ack0, ack1, done, cout}, 0);
        #2 rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(negedge clk);
            if (done || ack0 || ack1) n_done++;
        end
        chk("no_done_after_rst", n_done, 0);
        run_op(1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

        // Request withdrawn while busy is never acknowledged.
        @(negedge clk);
        req1 = 1'b1; a1 = 8'h21; b1 = 8'h43; cin1 = 1'b1;
        n_ack = 0;
        for (int k = 0; k < 10 && n_ack == 0; k++) begin
            @(negedge clk);
            if (ack1) n_ack = 1;
        end
        req1 = 1'b0;
        chk("wd_ack1", n_ack, 1);
        n_done = 0; n_ack0 = 0; seen_done = 1'b0;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (seen_done) begin
                chk("wd_busy_falls", busy, 0);
                seen_done = 1'b0;
            end
            if (k == 2) req0 = 1'b1;
            if (k == 5) req0 = 1'b0;
            if (ack0) n_ack0++;
            if (done) begin
                n_done++;
                seen_done = 1'b1;
                chk("wd_done_id", done_id, 1);
                chk("wd_result", {cout, sum}, ref_add(8'h21, 8'h43, 1'b1));
            end
        end
        chk("wd_done_count", n_done, 1);
        chk("wd_no_ack0", n_ack0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
